// File: rtl/pim_seq_pkg.sv
// Shared definitions for the PIM instruction sequencer and its neighbours:
// state encoding and default widths, so the instruction register and future
// controllers agree on sizes.
package pim_seq_pkg;

  localparam int unsigned PimDefN       = 38;
  localparam int unsigned PimDefAw      = 8;
  localparam int unsigned PimDefTimeout = 1024;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StWaitRd = 3'd2,
    StLoad   = 3'd3,
    StExec   = 3'd4,
    StFin    = 3'd5,
    StErr    = 3'd6
  } pim_seq_state_e;

endpackage

// File: rtl/pim_exec_timer.sv
// Execution watchdog: counts cycles while enabled and flags the cycle on
// which the count reaches TIMEOUT-1. Clear has priority over enable.
module pim_exec_timer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  logic [CntW-1:0] r_cnt;

  // Counter; saturates at the expiry value so it never wraps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/pim_instr_sequencer.sv
// Walks a contiguous window of instruction memory and issues one instruction
// at a time to the PIM instruction register, waiting for completion in between.
// All outputs are registers or state decodes; inputs act only at clock edges.
module pim_instr_sequencer
  import pim_seq_pkg::*;
#(
  parameter int unsigned N       = PimDefN,
  parameter int unsigned AW      = PimDefAw,
  parameter int unsigned TIMEOUT = PimDefTimeout
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [AW-1:0] i_base_addr,
  input  logic [AW-1:0] i_instr_count,
  output logic          o_imem_rd_en,
  output logic [AW-1:0] o_imem_addr,
  input  logic [N-1:0]  i_imem_rdata,
  output logic [N-1:0]  o_PIM_D,
  output logic          o_PIM_load,
  input  logic          i_pim_done,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [AW-1:0] o_remaining
);

  pim_seq_state_e r_state, w_state_nxt;
  logic [AW-1:0]  r_addr, w_addr_nxt;
  logic [AW-1:0]  r_rem, w_rem_nxt;
  logic [N-1:0]   r_pim_d, w_pim_d_nxt;
  logic [AW-1:0]  w_rem_dec;
  logic           w_expired;

  assign w_rem_dec = r_rem - AW'(1);

  pim_exec_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (r_state == StLoad),
    .i_en      (r_state == StExec),
    .o_expired (w_expired)
  );

  // State, address, count and instruction data registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_rem   <= '0;
      r_pim_d <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_rem   <= w_rem_nxt;
      r_pim_d <= w_pim_d_nxt;
    end
  end

  // Next-state logic; abort wins over everything and freezes the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_rem_nxt   = r_rem;
    w_pim_d_nxt = r_pim_d;
    if (i_abort && (r_state != StIdle)) begin
      w_state_nxt = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            w_addr_nxt  = i_base_addr;
            w_rem_nxt   = i_instr_count;
            w_state_nxt = (i_instr_count != '0) ? StFetch : StFin;
          end
        end
        StFetch:  w_state_nxt = StWaitRd;
        StWaitRd: begin
          w_pim_d_nxt = i_imem_rdata;
          w_state_nxt = StLoad;
        end
        StLoad:   w_state_nxt = StExec;
        StExec: begin
          // Completion in the same cycle as expiry counts as success.
          if (i_pim_done) begin
            w_rem_nxt   = w_rem_dec;
            w_addr_nxt  = r_addr + AW'(1);
            w_state_nxt = (w_rem_dec != '0) ? StFetch : StFin;
          end else if (w_expired) begin
            w_state_nxt = StErr;
          end
        end
        StFin:    w_state_nxt = StIdle;
        StErr:    w_state_nxt = StIdle;
        default:  w_state_nxt = StIdle;
      endcase
    end
  end

  assign o_imem_rd_en = (r_state == StFetch);
  assign o_imem_addr  = r_addr;
  assign o_PIM_D      = r_pim_d;
  assign o_PIM_load   = (r_state == StLoad);
  assign o_busy       = (r_state != StIdle);
  assign o_done       = (r_state == StFin);
  assign o_err        = (r_state == StErr);
  assign o_remaining  = r_rem;

endmodule

// File: tb/tb_pim_instr_sequencer.sv
// Directed bench for pim_instr_sequencer with a small instruction memory model.
module tb_pim_instr_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start, i_abort, i_pim_done;
  logic [7:0]  i_base_addr, i_instr_count;
  logic [37:0] i_imem_rdata;
  logic        o_imem_rd_en, o_PIM_load, o_busy, o_done, o_err;
  logic [7:0]  o_imem_addr, o_remaining;
  logic [37:0] o_PIM_D;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] base;
    logic [7:0] count;
    int         delay;     // pim_done this many cycles after PIM_load; 0 = never
    int         exp_loads;
    int         exp_reads;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_rem;
    logic [7:0] exp_last;  // last address read
  } vec_t;

  vec_t tbl[8];

  pim_instr_sequencer #(
    .N       (38),
    .AW      (8),
    .TIMEOUT (8)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_base_addr   (i_base_addr),
    .i_instr_count (i_instr_count),
    .o_imem_rd_en  (o_imem_rd_en),
    .o_imem_addr   (o_imem_addr),
    .i_imem_rdata  (i_imem_rdata),
    .o_PIM_D       (o_PIM_D),
    .o_PIM_load    (o_PIM_load),
    .i_pim_done    (i_pim_done),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err),
    .o_remaining   (o_remaining)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [37:0] mem_word(input logic [7:0] a);
    return {a[5:0] ^ 6'h2A, 24'hC0DE00, a};
  endfunction

  // Synchronous-read memory: data valid the cycle after the read strobe.
  initial i_imem_rdata = '0;
  always @(posedge i_clk) begin
    if (o_imem_rd_en) i_imem_rdata <= mem_word(o_imem_addr);
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [7:0] base, input logic [7:0] count);
    i_base_addr   = base;
    i_instr_count = count;
    i_start       = 1'b1;
    step();
    i_start       = 1'b0;
  endtask

  // Step n cycles, counting any strobes seen.
  task automatic watch(input int n, output int loads, output int dones, output int errs);
    loads = 0; dones = 0; errs = 0;
    for (int i = 0; i < n; i++) begin
      if (o_PIM_load) loads++;
      if (o_done) dones++;
      if (o_err) errs++;
      step();
    end
  endtask

  // Run one program from IDLE to IDLE and check it against the vector.
  task automatic run_row(input vec_t v);
    int cyc, loads, reads, dones, errs;
    int load_cyc, pd_cyc, done_cyc, err_cyc, end_cyc, last_evt;
    logic [7:0] ea;
    logic [7:0] last_addr;
    loads = 0; reads = 0; dones = 0; errs = 0;
    load_cyc = -100; pd_cyc = -100; done_cyc = -1; err_cyc = -1; end_cyc = -1;
    last_addr = '0;
    pulse_start(v.base, v.count);
    cyc = 1;
    while (cyc < 200) begin
      i_pim_done = 1'b0;
      if (!o_busy) begin
        end_cyc = cyc;
        break;
      end
      if (o_imem_rd_en) begin
        ea = v.base + 8'(reads);
        chk("rd_addr", o_imem_addr, ea);
        if (reads == 0) chk("first_fetch_cyc", cyc, 1);
        last_addr = o_imem_addr;
        reads++;
      end
      if (o_PIM_load) begin
        ea = v.base + 8'(loads);
        chk("load_data", o_PIM_D, mem_word(ea));
        chk("rem_at_load", o_remaining, v.count - 8'(loads));
        if (loads == 0) chk("first_load_cyc", cyc, 3);
        loads++;
        load_cyc = cyc;
      end
      if (o_done) begin dones++; done_cyc = cyc; end
      if (o_err) begin errs++; err_cyc = cyc; end
      if (v.delay != 0 && cyc == load_cyc + v.delay) begin
        i_pim_done = 1'b1;
        pd_cyc     = cyc;
      end
      step();
      cyc++;
    end
    i_pim_done = 1'b0;
    if (end_cyc < 0) begin
      bad++;
      total++;
      $display("FAIL run_timeout: busy still %0b after %0d cycles, required 0", o_busy, cyc);
    end
    chk("loads", loads, v.exp_loads);
    chk("reads", reads, v.exp_reads);
    chk("done_cnt", dones, v.exp_done);
    chk("err_cnt", errs, v.exp_err);
    chk("rem_final", o_remaining, v.exp_rem);
    if (v.exp_reads > 0) chk("last_addr", last_addr, v.exp_last);
    if (v.exp_done != 0) chk("done_cyc", done_cyc, (v.count == 0) ? 1 : pd_cyc + 1);
    if (v.exp_err != 0) chk("err_cyc", err_cyc, load_cyc + 9);
    last_evt = (done_cyc > err_cyc) ? done_cyc : err_cyc;
    chk("busy_fall", end_cyc, last_evt + 1);
  endtask

  initial begin
    int l, d, e;
    tbl[0] = '{8'h10, 8'd3, 5, 3, 3, 1, 0, 8'h00, 8'h12};
    tbl[1] = '{8'h20, 8'd0, 5, 0, 0, 1, 0, 8'h00, 8'h00};
    tbl[2] = '{8'hFE, 8'd3, 2, 3, 3, 1, 0, 8'h00, 8'h00};
    tbl[3] = '{8'h40, 8'd2, 0, 1, 1, 0, 1, 8'h02, 8'h40};
    tbl[4] = '{8'h50, 8'd1, 8, 1, 1, 1, 0, 8'h00, 8'h50};
    tbl[5] = '{8'h60, 8'd2, 1, 2, 2, 1, 0, 8'h00, 8'h61};
    tbl[6] = '{8'h70, 8'd2, 3, 2, 2, 1, 0, 8'h00, 8'h71};
    tbl[7] = '{8'hB0, 8'd1, 4, 1, 1, 1, 0, 8'h00, 8'hB0};

    i_rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_pim_done = 1'b0;
    i_base_addr = '0; i_instr_count = '0;
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_rd_en", o_imem_rd_en, 0);
    chk("rst_load", o_PIM_load, 0);
    chk("rst_pim_d", o_PIM_D, 0);
    chk("rst_rem", o_remaining, 0);
    step(); step();
    i_rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_row(tbl[i]);

    // Abort in WAIT_RD: no load, no done, then a fresh program runs normally.
    pulse_start(8'h70, 8'd2);
    step();
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    chk("abA_busy", o_busy, 0);
    chk("abA_load", o_PIM_load, 0);
    chk("abA_done", o_done, 0);
    chk("abA_err", o_err, 0);
    watch(4, l, d, e);
    chk("abA_quiet", {l[7:0], d[7:0], e[7:0]}, 0);
    run_row(tbl[6]);

    // Abort in the same cycle as pim_done: remaining must not decrement.
    pulse_start(8'h80, 8'd2);
    step(); step();
    chk("abB_load", o_PIM_load, 1);
    step(); step(); step();
    i_abort = 1'b1; i_pim_done = 1'b1;
    step();
    i_abort = 1'b0; i_pim_done = 1'b0;
    chk("abB_busy", o_busy, 0);
    chk("abB_done", o_done, 0);
    chk("abB_err", o_err, 0);
    chk("abB_rem", o_remaining, 2);
    watch(4, l, d, e);
    chk("abB_quiet", {l[7:0], d[7:0], e[7:0]}, 0);

    // Start while busy and pim_done during LOAD are ignored.
    pulse_start(8'h90, 8'd1);
    chk("ign_addr", o_imem_addr, 8'h90);
    i_start = 1'b1; i_base_addr = 8'h00; i_instr_count = 8'd5;
    step();
    i_start = 1'b0;
    step();
    chk("ign_load", o_PIM_load, 1);
    i_pim_done = 1'b1;
    step();
    i_pim_done = 1'b0;
    chk("ign_busy", o_busy, 1);
    chk("ign_rem", o_remaining, 1);
    chk("ign_done", o_done, 0);
    step(); step();
    i_pim_done = 1'b1;
    step();
    i_pim_done = 1'b0;
    chk("ign_fin", o_done, 1);
    chk("ign_rem0", o_remaining, 0);
    step();
    chk("ign_idle", o_busy, 0);

    // Asynchronous reset mid-EXEC.
    pulse_start(8'hA0, 8'd3);
    step(); step(); step(); step();
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("ar_busy", o_busy, 0);
    chk("ar_rd_en", o_imem_rd_en, 0);
    chk("ar_addr", o_imem_addr, 0);
    chk("ar_pim_d", o_PIM_D, 0);
    chk("ar_load", o_PIM_load, 0);
    chk("ar_done", o_done, 0);
    chk("ar_err", o_err, 0);
    chk("ar_rem", o_remaining, 0);
    step();
    i_rst_n = 1'b1;
    step();
    run_row(tbl[7]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
